// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/flush sequencer.
package hazard_pkg;

  localparam int DLY_W = 2;

  typedef enum logic {RUN, DELAY} hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter; clears on reset and sticks at all-ones.
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // count register with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and flush sequencer for the 5-stage core.
// Load-use detection, redirect flush with a post-redirect delay window,
// and whole-pipe freeze on memory wait. All decisions are combinational;
// only the delay window (state/dly_cnt) is registered.
// Optional: define HAZARD_PERF_EN to add saturating perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_DELAY = 1,
  parameter int REG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_jump,
  input  logic             ex_branch,
  input  logic             ex_branch_taken,
  input  logic             imem_wait,
  input  logic             dmem_wait,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             load_use_hazard,
  output logic             redirect,
  output logic             jump_delay,
  output logic             pipe_freeze
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_lu_cnt,
  output logic [31:0]      perf_flush_cnt,
  output logic [31:0]      perf_freeze_cnt
`endif
);

  hz_state_e        state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  hz_ctrl_t         ctrl;
  logic             lu_match, redir_req, mem_wait;

  assign mem_wait  = imem_wait | dmem_wait;
  assign redir_req = ex_jump | (ex_branch & ex_branch_taken);
  // x0 is never a real dependency, so a load to x0 never stalls
  assign lu_match  = ex_memread && (ex_rd != '0) &&
                     ((id_rs1_used && (id_rs1 == ex_rd)) ||
                      (id_rs2_used && (id_rs2 == ex_rd)));

  // priority decode: reset > freeze > redirect > delay window > load-use
  always_comb begin
    ctrl            = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                        idex_write: 1'b1, idex_flush: 1'b0};
    load_use_hazard = 1'b0;
    redirect        = 1'b0;
    pipe_freeze     = 1'b0;
    state_d         = state_q;
    dly_d           = dly_q;
    if (!rst) begin
      ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
               idex_write: 1'b0, idex_flush: 1'b1};
    end else if (mem_wait) begin
      // EX is held, so a pending transfer re-resolves once memory is ready
      pipe_freeze = 1'b1;
      ctrl        = '0;
    end else if (redir_req) begin
      redirect = 1'b1;
      ctrl     = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                   idex_write: 1'b1, idex_flush: 1'b1};
      dly_d    = FLUSH_DELAY[DLY_W-1:0];
      state_d  = (FLUSH_DELAY != 0) ? DELAY : RUN;
    end else if (state_q == DELAY) begin
      // fetches still in flight are wrong-path; squash them, ignore load-use
      ctrl    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                  idex_write: 1'b1, idex_flush: 1'b1};
      dly_d   = dly_q - 2'd1;
      state_d = (dly_q == 2'd1) ? RUN : DELAY;
    end else if (lu_match) begin
      // one bubble into EX; the load moves on to MEM next cycle
      load_use_hazard = 1'b1;
      ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
               idex_write: 1'b1, idex_flush: 1'b1};
    end
  end

  // delay-window state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
    end
  end

  assign pc_write   = ctrl.pc_write;
  assign ifid_write = ctrl.ifid_write;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_write = ctrl.idex_write;
  assign idex_flush = ctrl.idex_flush;
  assign jump_delay = (state_q == DELAY);

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.W(32)) u_lu_cnt (
    .clk(clk), .rst(rst), .inc(load_use_hazard), .cnt(perf_lu_cnt));
  hazard_perf_cnt #(.W(32)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(redirect | jump_delay), .cnt(perf_flush_cnt));
  hazard_perf_cnt #(.W(32)) u_freeze_cnt (
    .clk(clk), .rst(rst), .inc(pipe_freeze), .cnt(perf_freeze_cnt));
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: behavioural model + per-cycle compare, plus
// directed literal checks. Perf counters checked when HAZARD_PERF_EN is set.
module tb_hazard_ctrl;
  localparam int FD = 1;
  localparam int RW = 5;

  logic gclk = 1'b0;
  logic rst;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_memread, ex_jump, ex_branch, ex_branch_taken;
  logic imem_wait, dmem_wait;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic load_use_hazard, redirect, jump_delay, pipe_freeze;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_cnt, perf_flush_cnt, perf_freeze_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 gclk = ~gclk;

  hazard_ctrl #(.FLUSH_DELAY(FD), .REG_W(RW)) dut (
    .clk(gclk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_jump(ex_jump), .ex_branch(ex_branch),
    .ex_branch_taken(ex_branch_taken), .imem_wait(imem_wait), .dmem_wait(dmem_wait),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush), .load_use_hazard(load_use_hazard),
    .redirect(redirect), .jump_delay(jump_delay), .pipe_freeze(pipe_freeze)
`ifdef HAZARD_PERF_EN
    , .perf_lu_cnt(perf_lu_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_freeze_cnt(perf_freeze_cnt)
`endif
  );

  // ---------------- model ----------------
  // remaining flush cycles after a redirect; window is open while > 0
  int   m_left = 0;
  logic m_valid = 1'b0;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, lu, redirect, jump_delay, freeze}
  function automatic logic [8:0] model_out(input int left);
    logic frz, red, lu, jd;
    jd  = (left > 0);
    frz = imem_wait | dmem_wait;
    red = ex_jump | (ex_branch & ex_branch_taken);
    lu  = ex_memread && ex_rd != 0 &&
          ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    if (!rst)    return {5'b00101, 1'b0, 1'b0, jd, 1'b0};
    if (frz)     return {5'b00000, 1'b0, 1'b0, jd, 1'b1};
    if (red)     return {5'b11111, 1'b0, 1'b1, jd, 1'b0};
    if (jd)      return {5'b11111, 1'b0, 1'b0, jd, 1'b0};
    if (lu)      return {5'b00011, 1'b1, 1'b0, jd, 1'b0};
    return {5'b11010, 1'b0, 1'b0, jd, 1'b0};
  endfunction

  always @(posedge gclk) begin
    if (!rst) begin
      m_left  <= 0;
      m_valid <= 1'b1;
    end else if (imem_wait | dmem_wait) begin
      m_left <= m_left;
    end else if (ex_jump | (ex_branch & ex_branch_taken)) begin
      m_left <= FD;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
    end
  end

  // every-cycle compare against the model
  always @(negedge gclk) begin
    logic [8:0] exp_v, act_v;
    if (m_valid) begin
      exp_v = model_out(m_left);
      act_v = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
               load_use_hazard, redirect, jump_delay, pipe_freeze};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL model t=%0t got=%b want=%b", $time, act_v, exp_v);
      end
    end
  end

  // ---------------- directed ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge gclk); #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    ex_memread = 0; ex_rd = '0; ex_jump = 0; ex_branch = 0; ex_branch_taken = 0;
    imem_wait = 0; dmem_wait = 0;
  endtask

  task automatic set_lu(input logic [RW-1:0] rd);
    ex_memread = 1; ex_rd = rd; id_rs2 = 5'd5; id_rs2_used = 1;
  endtask

  initial begin
    idle();
    rst = 0;
    step(); step();
    @(negedge gclk); #1;
    chk("rst_pc_write", pc_write, 0);
    chk("rst_ifid_flush", ifid_flush, 1);
    chk("rst_idex_flush", idex_flush, 1);
    chk("rst_jump_delay", jump_delay, 0);
    step(); rst = 1;
    @(negedge gclk); #1;
    chk("post_rst_pc_write", pc_write, 1);

    // load-use: one bubble
    step(); set_lu(5'd5);
    @(negedge gclk); #1;
    chk("lu_hazard", load_use_hazard, 1);
    chk("lu_pc_write", pc_write, 0);
    chk("lu_ifid_write", ifid_write, 0);
    chk("lu_idex_flush", idex_flush, 1);
    step(); idle();
    @(negedge gclk); #1;
    chk("lu_one_cycle", load_use_hazard, 0);
    step(); set_lu(5'd0);
    @(negedge gclk); #1;
    chk("lu_x0_none", load_use_hazard, 0);
    chk("lu_x0_pc_write", pc_write, 1);

    // jump with one delay cycle
    step(); idle(); ex_jump = 1;
    @(negedge gclk); #1;
    chk("jmp_redirect", redirect, 1);
    chk("jmp_ifid_flush", ifid_flush, 1);
    chk("jmp_idex_flush", idex_flush, 1);
    chk("jmp_jd_n", jump_delay, 0);
    step(); ex_jump = 0;
    @(negedge gclk); #1;
    chk("jmp_jd_n1", jump_delay, 1);
    chk("jmp_flush_n1", ifid_flush, 1);
    step();
    @(negedge gclk); #1;
    chk("jmp_jd_n2", jump_delay, 0);

    // freeze inside the delay window
    step(); ex_jump = 1;
    step(); ex_jump = 0; dmem_wait = 1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge gclk); #1;
      chk("frz_pipe_freeze", pipe_freeze, 1);
      chk("frz_pc_write", pc_write, 0);
      chk("frz_idex_write", idex_write, 0);
      chk("frz_jd_held", jump_delay, 1);
      if (i < 3) step();
    end
    step(); dmem_wait = 0;
    @(negedge gclk); #1;
    chk("frz_jd_n4", jump_delay, 1);
    step();
    @(negedge gclk); #1;
    chk("frz_jd_n5", jump_delay, 0);

    // priority: redirect beats load-use; freeze beats both
    step(); set_lu(5'd5); ex_branch = 1; ex_branch_taken = 1;
    @(negedge gclk); #1;
    chk("pri_redirect", redirect, 1);
    chk("pri_no_lu", load_use_hazard, 0);
    imem_wait = 1;
    #1;
    chk("pri_frz", pipe_freeze, 1);
    chk("pri_frz_no_red", redirect, 0);
    chk("pri_frz_no_lu", load_use_hazard, 0);
    chk("pri_frz_no_flush", ifid_flush, 0);
    step(); idle();
    step(); step();

    // not-taken branch is not a redirect; back-to-back jumps reload the window
    step(); ex_branch = 1;
    @(negedge gclk); #1;
    chk("nt_branch", redirect, 0);
    step(); idle(); ex_jump = 1;
    step();
    step(); ex_jump = 0;
    @(negedge gclk); #1;
    chk("reload_jd", jump_delay, 1);
    step(); step();

    // short scrambled soak, checked by the model every cycle
    for (int i = 0; i < 150; i++) begin
      step();
      id_rs1 = RW'($urandom_range(0, 3)); id_rs2 = RW'($urandom_range(0, 3));
      ex_rd  = RW'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      ex_memread = 1'($urandom);
      ex_jump = ($urandom_range(0, 7) == 0);
      ex_branch = 1'($urandom); ex_branch_taken = 1'($urandom);
      imem_wait = ($urandom_range(0, 7) == 0);
      dmem_wait = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 49) != 0);
    end
    step(); idle(); rst = 1;
    step();

`ifdef HAZARD_PERF_EN
    rst = 0; step(); rst = 1;
    for (int i = 0; i < 3; i++) begin set_lu(5'd5); step(); idle(); step(); end
    dmem_wait = 1; repeat (4) step(); dmem_wait = 0;
    @(negedge gclk); #1;
    chk("perf_lu", perf_lu_cnt, 3);
    chk("perf_freeze", perf_freeze_cnt, 4);
    chk("perf_flush", perf_flush_cnt, 0);
`endif

    @(negedge gclk); #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
